// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment patterns and bit order shared by the scanner and its decoder
package seven_seg_pkg;

  // Active-low segment vector: bit 6 = a, bit 5 = b, ... bit 0 = g
  typedef logic [6:0] seg_t;

  // Named view of the same vector so the bit order is written down once
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_bits_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_DASH  = 7'b1111110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Non-decimal codes show a dash so a bad value is visible rather than garbled
  function automatic seg_t seg_pattern(input logic [3:0] code);
    case (code)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-low seven-segment decoder
module seg7_decode (
  input  logic [3:0] code,
  output logic [6:0] seg_n
);
  import seven_seg_pkg::*;

  // Pure table lookup; blanking is applied by the caller
  always_comb begin
    seg_n = seg_pattern(code);
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed seven-segment scanner with blink and leading-zero blanking
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);
  import seven_seg_pkg::*;

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] pend_bcd;
  logic [4*NUM_DIGITS-1:0] act_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   pend_blink;
  logic [NUM_DIGITS-1:0]   act_blink;

  logic                    tick;
  logic                    boundary;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    upper_zero;
  logic                    lz_blank;
  logic                    blink_blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              dec_seg;

  assign tick     = enable && (presc == PW'(SCAN_DIV - 1));
  assign boundary = tick && (idx == IW'(NUM_DIGITS - 1));

  // Slot prescaler; frozen while disabled so a re-enable resumes mid-slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Digit index advances once per slot and wraps at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= boundary ? '0 : idx + IW'(1);
    end
  end

  // Blink phase flips after every BLINK_FRAMES completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Pending capture; the last load before a boundary is the one that gets displayed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
    end else if (load) begin
      pend_bcd   <= bcd_in;
      pend_dp    <= dp_in;
      pend_blink <= blink_mask;
    end
  end

  // Active values only change at a frame boundary, bypassing pending when load coincides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_bcd   <= '0;
      act_dp    <= '0;
      act_blink <= '0;
    end else if (boundary) begin
      act_bcd   <= load ? bcd_in     : pend_bcd;
      act_dp    <= load ? dp_in      : pend_dp;
      act_blink <= load ? blink_mask : pend_blink;
    end
  end

  // Select the current digit and work out whether it is blanked
  always_comb begin
    cur_code   = 4'd0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    an_sel     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_code  = act_bcd[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blink = act_blink[i];
        an_sel[i] = 1'b0;
      end
      if ((IW'(i) >= idx) && (act_bcd[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    lz_blank    = blank_lz && (idx != '0) && upper_zero;
    blink_blank = blink_phase && cur_blink;
  end

  seg7_decode u_decode (
    .code  (cur_code),
    .seg_n (dec_seg)
  );

  // Registered drive of the display pins; disabled means everything dark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else if (!enable) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= (lz_blank || blink_blank) ? SEG_BLANK : dec_seg;
      dp_n  <= blink_blank ? 1'b1 : ~cur_dp;
      an_n  <= an_sel;
    end
  end

  // One-cycle pulse following the tick that closes a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int compared = 0;
  int failed   = 0;

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [6:0] SEGS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110
  };
  localparam logic [11:0] DARK = {7'b1111111, 1'b1, 4'b1111};

  // Reference model: e counts enabled clock edges since reset. Slot = e/4,
  // digit = slot mod 4, frames completed = e/16, blink phase = (e/16/2) mod 2.
  int          e_cnt;
  logic [15:0] m_pend_bcd, m_act_bcd;
  logic [3:0]  m_pend_dp, m_act_dp, m_pend_bl, m_act_bl;
  logic [11:0] exp_out;
  logic        exp_fd;

  function automatic logic [11:0] expect_out(input int e, input logic [15:0] bcd,
                                             input logic [3:0] dpv, input logic [3:0] bl,
                                             input logic lz);
    int         d      = (e / 4) % 4;
    int         ph     = (e / 32) % 2;
    logic [3:0] code   = bcd[d*4 +: 4];
    logic       zeros  = 1'b1;
    logic       lzb;
    logic       bb;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    for (int j = d; j < 4; j++) if (bcd[j*4 +: 4] != 4'd0) zeros = 1'b0;
    lzb = lz && (d > 0) && zeros;
    bb  = (ph == 1) && bl[d];
    seg = (lzb || bb) ? 7'b1111111 : SEGS[code];
    dp  = bb ? 1'b1 : ~dpv[d];
    an  = ~(4'b0001 << d);
    return {seg, dp, an};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt      <= 0;
      m_pend_bcd <= '0; m_pend_dp <= '0; m_pend_bl <= '0;
      m_act_bcd  <= '0; m_act_dp  <= '0; m_act_bl  <= '0;
      exp_out    <= DARK;
      exp_fd     <= 1'b0;
    end else begin
      if (load) begin
        m_pend_bcd <= bcd_in; m_pend_dp <= dp_in; m_pend_bl <= blink_mask;
      end
      if (enable) begin
        exp_out <= expect_out(e_cnt, m_act_bcd, m_act_dp, m_act_bl, blank_lz);
        exp_fd  <= (e_cnt % 16 == 15);
        if (e_cnt % 16 == 15) begin
          m_act_bcd <= load ? bcd_in     : m_pend_bcd;
          m_act_dp  <= load ? dp_in      : m_pend_dp;
          m_act_bl  <= load ? blink_mask : m_pend_bl;
        end
        e_cnt <= e_cnt + 1;
      end else begin
        exp_out <= DARK;
        exp_fd  <= 1'b0;
      end
    end
  end

  task automatic pulse_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] m);
    @(negedge clk);
    bcd_in = b; dp_in = d; blink_mask = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int modulus, input int target);
    int guard = 0;
    while ((e_cnt % modulus) != target && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (guard >= 200) begin
      failed++;
      $display("FAIL wait_phase: timed out waiting for model phase %0d of %0d", target, modulus);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({seg_n, dp_n, an_n, frame_done} !== {DARK, 1'b0}) begin
      failed++;
      $display("FAIL reset_state: got %b want %b", {seg_n, dp_n, an_n, frame_done}, {DARK, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan;
    int pulses = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      compared += 2;
      if ({seg_n, dp_n, an_n} !== exp_out) begin
        failed++;
        $display("FAIL scan c=%0d: got %b want %b", c, {seg_n, dp_n, an_n}, exp_out);
      end
      if (frame_done !== exp_fd) begin
        failed++;
        $display("FAIL scan_frame_done c=%0d: got %b want %b", c, frame_done, exp_fd);
      end
      if (c >= 16) pulses += int'(frame_done);
    end
    compared++;
    if (pulses != 2) begin
      failed++;
      $display("FAIL scan_pulse_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_leading_zero;
    blank_lz = 1'b1;
    pulse_load(16'h0907, 4'b0000, 4'b0000);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      compared++;
      if ({seg_n, dp_n, an_n} !== exp_out) begin
        failed++;
        $display("FAIL leading_zero c=%0d: got %b want %b", c, {seg_n, dp_n, an_n}, exp_out);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_last_load_wins;
    wait_phase(16, 4);
    pulse_load(16'h1234, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    pulse_load(16'h5678, 4'b0000, 4'b0000);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      compared++;
      if ({seg_n, dp_n, an_n} !== exp_out) begin
        failed++;
        $display("FAIL last_load_wins c=%0d: got %b want %b", c, {seg_n, dp_n, an_n}, exp_out);
      end
    end
  endtask

  task automatic test_blink;
    pulse_load(16'h4321, 4'b0001, 4'b0001);
    for (int c = 0; c < 112; c++) begin
      @(negedge clk);
      compared++;
      if ({seg_n, dp_n, an_n} !== exp_out) begin
        failed++;
        $display("FAIL blink c=%0d: got %b want %b", c, {seg_n, dp_n, an_n}, exp_out);
      end
    end
  endtask

  task automatic test_dash_enable;
    pulse_load(16'h12C4, 4'b0010, 4'b0000);
    wait_phase(16, 2);
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      compared++;
      if ({seg_n, dp_n, an_n} !== exp_out) begin
        failed++;
        $display("FAIL dash_enable c=%0d: got %b want %b", c, {seg_n, dp_n, an_n}, exp_out);
      end
      if (c == 22) enable = 1'b0;
      if (c == 24) begin
        compared++;
        if (an_n !== 4'b1111) begin
          failed++;
          $display("FAIL disabled_an: got %b want 1111", an_n);
        end
      end
      if (c == 29) enable = 1'b1;
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      compared += 3;
      if ({seg_n, dp_n, an_n} !== exp_out) begin
        failed++;
        $display("FAIL random c=%0d: got %b want %b", c, {seg_n, dp_n, an_n}, exp_out);
      end
      if (frame_done !== exp_fd) begin
        failed++;
        $display("FAIL random_frame_done c=%0d: got %b want %b", c, frame_done, exp_fd);
      end
      if ($countones(~an_n) > 1) begin
        failed++;
        $display("FAIL random_one_hot c=%0d: got %b want at most one low", c, an_n);
      end
      load       = ($urandom_range(7) == 0);
      bcd_in     = 16'($urandom);
      dp_in      = 4'($urandom);
      blink_mask = 4'($urandom);
      enable     = ($urandom_range(15) != 0);
      if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0; enable = 1'b1;
  endtask

  task automatic test_async_reset;
    pulse_load(16'h9876, 4'b1111, 4'b0000);
    wait_phase(4, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({seg_n, dp_n, an_n, frame_done} !== {DARK, 1'b0}) begin
      failed++;
      $display("FAIL async_reset: got %b want %b", {seg_n, dp_n, an_n, frame_done}, {DARK, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      compared++;
      if ({seg_n, dp_n, an_n} !== exp_out) begin
        failed++;
        $display("FAIL after_reset c=%0d: got %b want %b", c, {seg_n, dp_n, an_n}, exp_out);
      end
      if (c == 0) begin
        compared++;
        if (an_n !== 4'b1110 || seg_n !== 7'b0000001) begin
          failed++;
          $display("FAIL first_slot: got an=%b seg=%b want an=1110 seg=0000001", an_n, seg_n);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    bcd_in = '0; dp_in = '0; blink_mask = '0; blank_lz = 1'b0;
    test_reset;
    test_scan;
    test_leading_zero;
    test_last_load_wins;
    test_blink;
    test_dash_enable;
    test_random;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per digit slot, legal minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64, full frames per blink half-period, legal minimum 1.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  scan enable; low holds all counters and blanks the display.
REQ-007 load  in  1  single-cycle strobe capturing bcd_in, dp_in and blink_mask.
REQ-008 bcd_in  in  4*NUM_DIGITS  packed BCD codes; digit i at bits [4i+3:4i]; digit 0 is least significant.
REQ-009 dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-010 blink_mask  in  NUM_DIGITS  per-digit blink enable, active-high.
REQ-011 blank_lz  in  1  leading-zero suppression enable, sampled live.
REQ-012 seg_n  out  7  active-low segments; bit 6 = a through bit 0 = g.
REQ-013 dp_n  out  1  active-low decimal point.
REQ-014 an_n  out  NUM_DIGITS  active-low digit select; at most one bit low.
REQ-015 frame_done  out  1  one-cycle pulse when the last digit slot of a frame ends.

Function
REQ-016 Prescaler counts 0..SCAN_DIV-1 while enable=1; tick asserts when the count equals SCAN_DIV-1, and the count then wraps to 0.
REQ-017 On tick, digit index increments; NUM_DIGITS-1 wraps to 0, and this wrap is the frame boundary.
REQ-018 frame_done is registered high for exactly the cycle following a frame-boundary tick.
REQ-019 load writes bcd_in, dp_in and blink_mask into pending registers; pending is copied to active registers at each frame boundary.
REQ-020 If load coincides with a frame-boundary tick, active receives the new input values directly in the same edge.
REQ-021 Multiple loads within one frame: the last one wins; the display never shows a mix of two loads within one frame.
REQ-022 Decode: codes 0-9 give the standard pattern (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100); codes 10-15 give dash 1111110.
REQ-023 Leading-zero suppression: when blank_lz=1, digit i>0 is blanked if it and every more-significant active digit equal 0; digit 0 is never suppressed.
REQ-024 Blink: blink_phase toggles after every BLINK_FRAMES frame boundaries; while blink_phase=1, digits with an active blink_mask bit are blanked.
REQ-025 A blanked digit drives seg_n=1111111 and dp_n=1, while its an_n bit remains low.
REQ-026 dp_n = ~active dp bit of the current digit unless that digit is blanked by blink; leading-zero suppression does not blank the dp.
REQ-027 seg_n, dp_n and an_n are registered; they reflect the new digit index one cycle after the tick (latency 1).
REQ-028 enable=0: prescaler, index, blink counter and pending-to-active transfer freeze; an_n=all ones and seg_n=1111111 from the next cycle; load still updates pending.
REQ-029 On enable rising, scanning resumes from the frozen index and count without skipping a slot.

Reset
REQ-030 rst_n low immediately forces: prescaler=0, index=0, blink counter=0, blink_phase=0, pending and active registers=0, seg_n=1111111, dp_n=1, an_n=all ones, frame_done=0.
REQ-031 Reset asserted mid-frame discards pending data; after release, the first slot selects digit 0 and an_n[0] goes low one cycle after enable is sampled high.

Structure
REQ-032 A shared package seven_seg_pkg holds the segment pattern constants (digits 0-9, DASH, BLANK) and the segment bit-order definition.
REQ-033 Sub-module seg7_decode (combinational: 4-bit code in, 7-bit active-low pattern out) is instantiated once on the muxed active digit.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-034 Reset, enable=1 -> an_n cycles 1110,1101,1011,0111 every 4 clocks; frame_done pulses once per 16 clocks.
REQ-035 load bcd_in=16'h0907, blank_lz=1 -> next frame digit3 blank, digit2 shows 9 (0000100), digit1 shows 0, digit0 shows 7 (0001111).
REQ-036 load 16'h1234 at mid-frame, then 16'h5678 before boundary -> next frame shows only 5,6,7,8; no frame shows mixed digits.
REQ-037 blink_mask=4'b0001 -> digit0 segments 1111111 during alternate 2-frame periods, other digits steady; dp_in=4'b0001 also blanked then.
REQ-038 bcd_in nibble=4'hC -> seg_n=1111110; enable dropped mid-slot -> an_n=1111 next cycle, resumes same digit on re-enable.
REQ-039 rst_n asserted asynchronously mid-slot -> outputs reach reset values without a clock edge.
